// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared defaults and FSM state codes for the I2S capture path
package i2s_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int DEPTH_DEF   = 8;
    localparam int FRAME_W_DEF = 16;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_STOP = 2'd2;

endpackage

// File: rtl/i2s_sample_fifo.sv
// rtl/i2s_sample_fifo.sv - synchronous first-word-fall-through sample FIFO
module i2s_sample_fifo
    import i2s_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic [AW:0]       level,
    output logic [AW:0]       level_nxt,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    // A pop frees the slot this same cycle, so a push into a full FIFO still lands.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr];

    always_comb begin
        level_nxt = level;
        if (do_push && !do_pop) begin
            level_nxt = level + 1'b1;
        end else if (do_pop && !do_push) begin
            level_nxt = level - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            level <= level_nxt;
            if (do_push) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2s_capture_ctrl.sv
// rtl/i2s_capture_ctrl.sv - I2S receiver sequencer with sample FIFO, frame count and irq
module i2s_capture_ctrl
    import i2s_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int AW      = 3,
    parameter int FRAME_W = FRAME_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [FRAME_W-1:0] frames,
    input  logic [AW:0]        watermark,
    output logic               i2s_en,
    input  logic               i2s_done,
    input  logic [DATA_W-1:0]  i2s_data,
    input  logic               rd_en,
    output logic [DATA_W-1:0]  rd_data,
    output logic [AW:0]        level,
    output logic               empty,
    output logic               full,
    output logic [FRAME_W-1:0] captured,
    output logic               busy,
    output logic               overflow,
    output logic               irq,
    input  logic               irq_clr
);

    state_t             state;
    state_t             state_nxt;
    logic [FRAME_W-1:0] frames_q;
    logic [FRAME_W-1:0] captured_inc;
    logic [AW:0]        level_nxt;
    logic               run_done;
    logic               drop;
    logic               stop_entry;
    logic               wm_cross;
    logic               irq_set;

    i2s_sample_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (run_done),
        .wdata     (i2s_data),
        .pop       (rd_en),
        .rdata     (rd_data),
        .level     (level),
        .level_nxt (level_nxt),
        .full      (full),
        .empty     (empty)
    );

    assign busy         = (state != ST_IDLE);
    assign run_done     = (state == ST_RUN) && i2s_done;
    assign drop         = run_done && full && !rd_en;
    assign captured_inc = (captured == '1) ? captured : captured + 1'b1;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN: begin
                if (stop || (run_done && frames_q != '0 && captured_inc == frames_q)) begin
                    state_nxt = ST_STOP;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign stop_entry = (state == ST_RUN) && (state_nxt == ST_STOP);
    // Edge on the FIFO level itself, so a level that merely stays above the mark never re-fires.
    assign wm_cross   = (watermark != '0) && (level < watermark) && (level_nxt >= watermark);
    assign irq_set    = stop_entry || wm_cross || (drop && !overflow);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            i2s_en   <= 1'b0;
            frames_q <= '0;
            captured <= '0;
            overflow <= 1'b0;
            irq      <= 1'b0;
        end else begin
            state  <= state_nxt;
            i2s_en <= (state_nxt == ST_RUN);
            if (state == ST_IDLE && start) begin
                frames_q <= frames;
                captured <= '0;
                overflow <= 1'b0;
            end else begin
                if (run_done) captured <= captured_inc;
                if (drop)     overflow <= 1'b1;
            end
            if (irq_set) begin
                irq <= 1'b1;
            end else if (irq_clr) begin
                irq <= 1'b0;
            end
        end
    end

endmodule

// File: doc/i2s_capture_ctrl.md
Name: i2s_capture_ctrl

Overview:
Controller that sequences the I2S receiver. It gates the receiver enable, collects each completed 32-bit sample into a small FIFO, and counts captured frames. It raises a sticky interrupt at a programmable watermark or on capture completion, so CPU firmware drains samples by interrupt instead of polling. It sits between the I2S receiver (en/done/data) and the SoC register/interrupt fabric.

Parameters:
DATA_W, 32, sample width; matches the receiver data bus.
DEPTH, 8, FIFO entries; power of two, at least 2.
AW, 3, log2(DEPTH).
FRAME_W, 16, width of the frame-count fields.

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle pulse; begin capture from IDLE.
stop  in  1  one-cycle pulse; abort capture.
frames  in  FRAME_W  samples to capture; 0 = continuous; sampled on start.
watermark  in  AW+1  FIFO level that triggers irq; 0 = watermark irq disabled.
i2s_en  out  1  receiver enable.
i2s_done  in  1  one-cycle pulse; i2s_data valid this cycle.
i2s_data  in  DATA_W  received sample.
rd_en  in  1  pop FIFO head.
rd_data  out  DATA_W  FIFO head (first-word-fall-through).
level  out  AW+1  FIFO occupancy, 0..DEPTH.
empty  out  1  level==0.
full  out  1  level==DEPTH.
captured  out  FRAME_W  samples accepted since last start.
busy  out  1  state != IDLE.
overflow  out  1  sticky; sample dropped because FIFO full.
irq  out  1  sticky interrupt.
irq_clr  in  1  clears irq.

Behaviour:
- Reset (async, rst_n=0): state IDLE; i2s_en=0; FIFO pointers and level=0; empty=1, full=0; captured=0; overflow=0; irq=0; busy=0; rd_data=0.
- States: IDLE, RUN, STOP.
  - IDLE: on start, latch frames into frames_q, clear captured, clear overflow, go to RUN. stop in IDLE is ignored. The FIFO is not flushed, so leftover samples remain readable.
  - RUN: i2s_en=1, registered, high from the first RUN cycle. Each i2s_done pushes i2s_data and increments captured. Exit to STOP when stop=1, or when frames_q!=0 and this push makes captured==frames_q. start in RUN is ignored.
  - STOP: i2s_en=0; i2s_done is ignored; exactly one cycle, then IDLE. A completion-irq event fires on entry to STOP.
- i2s_done and stop in the same cycle: the sample is accepted, then the block goes to STOP.
- i2s_done outside RUN: ignored; captured is unchanged.
- FIFO:
  - Push when i2s_done in RUN and (not full, or rd_en this cycle). Push and pop in the same cycle while full both succeed and level is unchanged.
  - Push while full without rd_en drops the sample, sets overflow, and still increments captured.
  - rd_en while empty is ignored.
  - Pointers wrap modulo DEPTH.
  - rd_data = mem[rptr], combinational; undefined-free (0) when empty is not required.
- captured: saturates at all-ones in continuous mode.
- irq:
  - Set on the cycle level transitions from < watermark to >= watermark (watermark!=0).
  - Set on entry to STOP.
  - Set on the first overflow event.
  - irq_clr clears it. Set wins over clear in the same cycle.
- All outputs are registered except rd_data, empty, full and busy, which decode from registered state.

Decomposition:
- Package i2s_pkg: state enum (IDLE=2'd0, RUN=2'd1, STOP=2'd2), DATA_W/DEPTH/FRAME_W defaults.
- Sub-module i2s_sample_fifo: parametrised sync FWFT FIFO with push, pop, level, full, empty.
- i2s_capture_ctrl holds the FSM, frame counter and irq/overflow logic.

Test Plan:
- Reset mid-RUN with 3 samples buffered: assert rst_n=0 -> i2s_en=0, level=0, irq=0, busy=0 immediately, without waiting for a clk edge.
- frames=4, watermark=0, start, 4 done pulses with data 0xA0..0xA3 -> i2s_en falls the cycle after the 4th push; captured=4; irq=1; pops return A0,A1,A2,A3; empty=1.
- frames=0, watermark=3, no reads -> irq rises the cycle level becomes 3; irq_clr with no new push -> irq=0; the 4th push does not re-raise irq.
- frames=0, no reads, 10 done pulses -> level=8, full=1, overflow=1, captured=10; rd_en held with a done on the same cycle while full -> level stays 8 and the new sample enters.
- stop coincident with a done carrying 0x55 -> 0x55 is stored, state goes STOP then IDLE, i2s_en=0; a later done is ignored and captured is unchanged.
- irq_clr and a watermark crossing in the same cycle -> irq remains 1; rd_en on an empty FIFO -> level stays 0, no pointer change.
